// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake and 2-entry skid.
// Ports: clk, reset (sync, active-high), flush, in_* (valid/ready/data/rd),
//   out_* (valid/ready/data/rd), bubble_cnt (saturating idle-slot count).
module pipe_stage_skid #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [RD_W-1:0]   in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [RD_W-1:0]   out_rd,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  logic              m_v_q, m_v_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic [RD_W-1:0]   m_rd_q, m_rd_d;
  logic              s_v_q, s_v_d;
  logic [DATA_W-1:0] s_data_q, s_data_d;
  logic [RD_W-1:0]   s_rd_q, s_rd_d;
  logic              rdy_q, rdy_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  state_t state;
  logic   in_fire;
  logic   out_fire;

  // The occupancy flags are the state; S valid without M is unreachable.
  always_comb begin
    state = EMPTY;
    if (m_v_q && s_v_q)
      state = TWO;
    else if (m_v_q)
      state = ONE;
  end

  assign in_fire  = in_valid && rdy_q;
  assign out_fire = m_v_q && out_ready;

  always_comb begin
    m_v_d    = m_v_q;
    m_data_d = m_data_q;
    m_rd_d   = m_rd_q;
    s_v_d    = s_v_q;
    s_data_d = s_data_q;
    s_rd_d   = s_rd_q;

    unique case (state)
      EMPTY: begin
        if (in_fire) begin
          m_v_d    = 1'b1;
          m_data_d = in_data;
          m_rd_d   = in_rd;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          m_data_d = in_data;
          m_rd_d   = in_rd;
        end else if (out_fire) begin
          m_v_d    = 1'b0;
          m_data_d = '0;
          m_rd_d   = '0;
        end else if (in_fire) begin
          s_v_d    = 1'b1;
          s_data_d = in_data;
          s_rd_d   = in_rd;
        end
      end
      TWO: begin
        if (out_fire) begin
          m_data_d = s_data_q;
          m_rd_d   = s_rd_q;
          s_v_d    = 1'b0;
          s_data_d = '0;
          s_rd_d   = '0;
        end
      end
      default: begin
        m_v_d = 1'b0;
        s_v_d = 1'b0;
      end
    endcase

    if (flush) begin
      m_v_d    = 1'b0;
      m_data_d = '0;
      m_rd_d   = '0;
      s_v_d    = 1'b0;
      s_data_d = '0;
      s_rd_d   = '0;
    end

    // Ready is the registered copy of "skid empty next cycle".
    rdy_d = !s_v_d;

    // Counts on pre-flush outputs; sticks at all-ones.
    cnt_d = cnt_q;
    if (out_ready && !m_v_q && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m_v_q    <= 1'b0;
      m_data_q <= '0;
      m_rd_q   <= '0;
      s_v_q    <= 1'b0;
      s_data_q <= '0;
      s_rd_q   <= '0;
      rdy_q    <= 1'b1;
      cnt_q    <= '0;
    end else begin
      m_v_q    <= m_v_d;
      m_data_q <= m_data_d;
      m_rd_q   <= m_rd_d;
      s_v_q    <= s_v_d;
      s_data_q <= s_data_d;
      s_rd_q   <= s_rd_d;
      rdy_q    <= rdy_d;
      cnt_q    <= cnt_d;
    end
  end

  assign in_ready   = rdy_q;
  assign out_valid  = m_v_q;
  assign out_data   = m_v_q ? m_data_q : '0;
  assign out_rd     = m_v_q ? m_rd_q : '0;
  assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed scenarios plus random traffic
// compared against a queue-based model of a 2-deep in-order buffer.
module tb_pipe_stage_skid;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready, in_ready2;
  logic [31:0] in_data;
  logic [4:0]  in_rd;
  logic        out_valid, out_valid2;
  logic        out_ready;
  logic [31:0] out_data, out_data2;
  logic [4:0]  out_rd, out_rd2;
  logic [15:0] bubble_cnt;
  logic [1:0]  bubble_cnt2;

  int vec = 0;
  int errs = 0;

  logic [31:0] dq[$];
  logic [4:0]  rq[$];
  bit          mrdy;
  int          mcnt;
  int          mcnt2;

  always #5 clk = ~clk;

  pipe_stage_skid #(.DATA_W(32), .RD_W(5), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_rd(out_rd),
    .bubble_cnt(bubble_cnt)
  );

  pipe_stage_skid #(.DATA_W(32), .RD_W(5), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready2),
    .in_data(in_data), .in_rd(in_rd),
    .out_valid(out_valid2), .out_ready(out_ready),
    .out_data(out_data2), .out_rd(out_rd2),
    .bubble_cnt(bubble_cnt2)
  );

  // Drive one cycle, advance the model, wait past the edge.
  task automatic tick(input bit r, input bit f, input bit v,
                      input logic [31:0] d, input logic [4:0] rdv,
                      input bit ordy);
    bit ifire, ofire;
    reset = r; flush = f; in_valid = v;
    in_data = d; in_rd = rdv; out_ready = ordy;
    if (r) begin
      dq.delete(); rq.delete();
      mrdy = 1; mcnt = 0; mcnt2 = 0;
    end else begin
      if (ordy && dq.size() == 0) begin
        if (mcnt < 65535) mcnt++;
        if (mcnt2 < 3) mcnt2++;
      end
      if (f) begin
        dq.delete(); rq.delete();
        mrdy = 1;
      end else begin
        ifire = v && mrdy;
        ofire = (dq.size() > 0) && ordy;
        if (ofire) begin
          void'(dq.pop_front());
          void'(rq.pop_front());
        end
        if (ifire) begin
          dq.push_back(d);
          rq.push_back(rdv);
        end
        mrdy = dq.size() < 2;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit ordy);
    tick(0, 0, 0, 32'h0, 5'd0, ordy);
  endtask

  task automatic test_reset;
    tick(1, 0, 1, 32'hDEADBEEF, 5'd7, 0);
    tick(1, 0, 1, 32'hDEADBEEF, 5'd7, 0);
    idle(0);
    vec++;
    if (out_valid !== 1'b0) begin
      errs++; $display("FAIL rst_valid got %0b want 0", out_valid);
    end
    vec++;
    if (out_data !== 32'h0) begin
      errs++; $display("FAIL rst_data got %h want 0", out_data);
    end
    vec++;
    if (out_rd !== 5'd0) begin
      errs++; $display("FAIL rst_rd got %0d want 0", out_rd);
    end
    vec++;
    if (in_ready !== 1'b1) begin
      errs++; $display("FAIL rst_ready got %0b want 1", in_ready);
    end
    vec++;
    if (bubble_cnt !== 16'd0) begin
      errs++; $display("FAIL rst_bubble got %0d want 0", bubble_cnt);
    end
  endtask

  task automatic test_streaming;
    tick(1, 0, 0, 32'h0, 5'd0, 1);
    for (int i = 1; i <= 8; i++) begin
      tick(0, 0, 1, 32'(i), 5'(i), 1);
      vec++;
      if (out_valid !== 1'b1 || out_data !== 32'(i)
          || out_rd !== 5'(i)) begin
        errs++;
        $display("FAIL stream_%0d got v=%0b d=%0d rd=%0d want v=1 d=%0d rd=%0d",
                 i, out_valid, out_data, out_rd, i, i);
      end
      vec++;
      if (in_ready !== 1'b1) begin
        errs++; $display("FAIL stream_ready_%0d got %0b want 1", i, in_ready);
      end
    end
    idle(1);
    vec++;
    if (out_valid !== 1'b0) begin
      errs++; $display("FAIL stream_drain got %0b want 0", out_valid);
    end
  endtask

  task automatic test_stall;
    tick(1, 0, 0, 32'h0, 5'd0, 0);
    tick(0, 0, 1, 32'hA, 5'd10, 1);
    tick(0, 0, 1, 32'hB, 5'd11, 0);
    vec++;
    if (out_data !== 32'hA || out_rd !== 5'd10 || in_ready !== 1'b0) begin
      errs++;
      $display("FAIL stall_skid got d=%h rd=%0d rdy=%0b want d=a rd=10 rdy=0",
               out_data, out_rd, in_ready);
    end
    tick(0, 0, 1, 32'hC, 5'd12, 0);
    vec++;
    if (out_data !== 32'hA || out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errs++;
      $display("FAIL stall_hold got d=%h v=%0b rdy=%0b want d=a v=1 rdy=0",
               out_data, out_valid, in_ready);
    end
    tick(0, 0, 1, 32'hC, 5'd12, 1);
    vec++;
    if (out_data !== 32'hB || out_rd !== 5'd11 || in_ready !== 1'b1) begin
      errs++;
      $display("FAIL stall_b got d=%h rd=%0d rdy=%0b want d=b rd=11 rdy=1",
               out_data, out_rd, in_ready);
    end
    tick(0, 0, 1, 32'hC, 5'd12, 1);
    vec++;
    if (out_data !== 32'hC || out_rd !== 5'd12) begin
      errs++;
      $display("FAIL stall_c got d=%h rd=%0d want d=c rd=12", out_data, out_rd);
    end
    idle(1);
    vec++;
    if (out_valid !== 1'b0) begin
      errs++; $display("FAIL stall_drain got %0b want 0", out_valid);
    end
  endtask

  task automatic test_flush;
    tick(1, 0, 0, 32'h0, 5'd0, 0);
    tick(0, 0, 1, 32'hA, 5'd3, 1);
    tick(0, 0, 1, 32'hB, 5'd4, 0);
    tick(0, 1, 1, 32'hD, 5'd6, 0);
    vec++;
    if (out_valid !== 1'b0 || out_rd !== 5'd0 || in_ready !== 1'b1
        || out_data !== 32'h0) begin
      errs++;
      $display("FAIL flush_two got v=%0b rd=%0d rdy=%0b d=%h want 0 0 1 0",
               out_valid, out_rd, in_ready, out_data);
    end
    idle(1);
    idle(1);
    vec++;
    if (out_valid !== 1'b0) begin
      errs++; $display("FAIL flush_gone got v=%0b want 0", out_valid);
    end
  endtask

  task automatic test_bubble;
    tick(1, 0, 0, 32'h0, 5'd0, 0);
    for (int i = 0; i < 5; i++) idle(1);
    vec++;
    if (bubble_cnt !== 16'd5) begin
      errs++; $display("FAIL bubble_5 got %0d want 5", bubble_cnt);
    end
    idle(1);
    vec++;
    if (bubble_cnt2 !== 2'd3) begin
      errs++; $display("FAIL bubble_sat got %0d want 3", bubble_cnt2);
    end
    tick(0, 1, 0, 32'h0, 5'd0, 1);
    vec++;
    if (bubble_cnt !== 16'd7) begin
      errs++; $display("FAIL bubble_flush got %0d want 7", bubble_cnt);
    end
  endtask

  task automatic test_simul;
    tick(1, 0, 0, 32'h0, 5'd0, 0);
    tick(0, 0, 1, 32'h1111, 5'd1, 0);
    tick(0, 0, 1, 32'h2222, 5'd2, 1);
    vec++;
    if (out_data !== 32'h2222 || out_rd !== 5'd2 || in_ready !== 1'b1) begin
      errs++;
      $display("FAIL simul got d=%h rd=%0d rdy=%0b want d=2222 rd=2 rdy=1",
               out_data, out_rd, in_ready);
    end
    idle(1);
    vec++;
    if (out_valid !== 1'b0) begin
      errs++; $display("FAIL simul_drain got v=%0b want 0", out_valid);
    end
  endtask

  task automatic test_random;
    logic [31:0] ed;
    logic [4:0]  er;
    bit          ev;
    tick(1, 0, 0, 32'h0, 5'd0, 0);
    for (int i = 0; i < 400; i++) begin
      tick(0, ($urandom_range(0, 19) == 0), 1'($urandom),
           $urandom, 5'($urandom), ($urandom_range(0, 9) < 7));
      ev = dq.size() > 0;
      ed = ev ? dq[0] : 32'h0;
      er = ev ? rq[0] : 5'd0;
      vec++;
      if (out_valid !== ev || out_data !== ed || out_rd !== er) begin
        errs++;
        $display("FAIL rand_out_%0d got v=%0b d=%h rd=%0d want v=%0b d=%h rd=%0d",
                 i, out_valid, out_data, out_rd, ev, ed, er);
      end
      vec++;
      if (in_ready !== mrdy) begin
        errs++;
        $display("FAIL rand_ready_%0d got %0b want %0b", i, in_ready, mrdy);
      end
      vec++;
      if (bubble_cnt !== 16'(mcnt) || bubble_cnt2 !== 2'(mcnt2)) begin
        errs++;
        $display("FAIL rand_bubble_%0d got %0d/%0d want %0d/%0d",
                 i, bubble_cnt, bubble_cnt2, mcnt, mcnt2);
      end
    end
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0;
    in_data = '0; in_rd = '0; out_ready = 1'b0;
    mrdy = 1; mcnt = 0; mcnt2 = 0;
    test_reset();
    test_streaming();
    test_stall();
    test_flush();
    test_bubble();
    test_simul();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised pipeline stage register with valid/ready handshake, a two-entry skid buffer and synchronous flush. It is the generic replacement for the fixed-field ID/EX-style stage registers: any stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB) packs its control and data fields into one payload vector and carries the destination register separately so hazard logic can read it. It adds real back-pressure, which the fixed stage registers lack: the downstream stage can stall without losing an instruction. Its input ready is registered to break the combinational ready chain.

## Interface
- DATA_W, 32, width of the packed payload (control plus data fields)
- RD_W, 5, width of the destination-register field
- CNT_W, 16, width of the bubble counter
- clk  input  1  rising-edge clock; the only clock
- reset  input  1  synchronous, active-high reset
- flush  input  1  synchronous squash of all held entries
- in_valid  input  1  upstream offers an entry
- in_ready  output  1  stage can accept; registered
- in_data  input  DATA_W  payload
- in_rd  input  RD_W  destination register; 0 means none
- out_valid  output  1  output holds a live entry
- out_ready  input  1  downstream accepts
- out_data  output  DATA_W  payload of the main entry; 0 when not valid
- out_rd  output  RD_W  destination register of the main entry; 0 when not valid
- bubble_cnt  output  CNT_W  count of downstream-ready cycles with no valid output; saturating

## Operation
- **Storage:** main entry M (M_v, M_data, M_rd) drives the outputs. Skid entry S (S_v, S_data, S_rd) holds one overflow entry.
- **State encoding:**
  - EMPTY: !M_v
  - ONE: M_v && !S_v
  - TWO: M_v && S_v
  - The state S_v && !M_v is illegal and never reachable.
- **Signal definitions:**
  - in_ready = !S_v, registered.
  - in_fire = in_valid && in_ready.
  - out_fire = M_v && out_ready.
- **Transitions when reset=0 and flush=0:**
  - EMPTY, in_fire: M <= in, go to ONE. No in_fire: hold.
  - ONE, in_fire and out_fire: M <= in, stay in ONE.
  - ONE, out_fire only: M_v <= 0, M_data/M_rd <= 0, go to EMPTY.
  - ONE, in_fire only: S <= in, go to TWO; in_ready goes 0 next cycle.
  - ONE, neither: hold.
  - TWO, out_fire: M <= S, S_v <= 0, S_data/S_rd <= 0, go to ONE.
  - TWO, no out_fire: hold. in_valid is ignored because in_ready=0.
- **Flush:**
  - Clears M_v and S_v and zeroes all data and rd fields; the state becomes EMPTY.
  - Any in_fire in the same cycle is discarded.
  - Flush does not clear bubble_cnt.
- **Reset:** same effect as flush, and also sets bubble_cnt <= 0. Reset has priority over flush, which has priority over the handshake.
- **Bubbles:**
  - Invalid entries always present out_data=0 and out_rd=0, so hazard units can compare out_rd without gating on out_valid.
  - Payload bits of an entry with in_rd=0 pass through unchanged.
- **bubble_cnt:** increments by 1 in any cycle with out_ready=1 and out_valid=0. It holds at 2^CNT_W-1 and does not wrap. This update also applies during a flush cycle, since it is evaluated on the pre-flush outputs.

## Timing
- **Reset values:** in_ready=1, out_valid=0, out_data=0, out_rd=0, bubble_cnt=0.
- **Latency:** 1 cycle. An entry accepted at edge N appears on out_* after edge N, provided the stage was EMPTY or ONE with out_fire.
- **Throughput:** 1 entry per cycle when out_ready is held at 1; in_ready then stays 1.
- **Stall:** when out_ready drops, at most one more entry is accepted (into S). in_ready falls one cycle after out_ready falls, and rises one cycle after the first out_fire in TWO.
- **Ordering:** entries leave strictly in acceptance order. No entry is duplicated or dropped except by flush or reset.
- **Output stability:** while out_valid=1 and out_ready=0, out_data and out_rd are stable.
- **Mid-operation:** reset or flush in TWO returns to EMPTY with in_ready=1 on the following cycle.

## Test plan
- **Reset:** hold reset 2 cycles with in_valid=1, in_data=32'hDEADBEEF, in_rd=7. Required: out_valid=0, out_data=0, out_rd=0, in_ready=1, bubble_cnt=0 after release.
- **Streaming:** out_ready=1; send payloads 1..8 with rd=1..8 back-to-back. Required: outputs appear one cycle later in order, in_ready stays 1 throughout, no loss.
- **Stall/skid:** with A in M, drop out_ready and offer B then C. Required: B is accepted into S, in_ready=0 on the next cycle, C is held upstream. After raising out_ready, the output order is A, B, C, and out_data stays stable while stalled.
- **Flush in TWO:** with A in M and B in S, assert flush together with in_valid (D). Required: next cycle out_valid=0, out_rd=0, in_ready=1, and A, B and D never appear.
- **Bubble counter:** out_ready=1 with no input for 5 cycles. Required: bubble_cnt=5. With CNT_W=2 and 6 such cycles, it saturates at 3.
- **Simultaneous in/out in ONE:** with A in M, out_ready=1 and in_valid=1 (B). Required: next cycle out_data=B, S_v stays 0, in_ready=1.
